// File: rtl/modclk_pkg.sv
// Shared types and constants for the modulation clock monitor.
package modclk_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } modclk_state_e;

    // Synchronized level plus one-cycle edge strobes of one input channel
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_ev_t;

    // All-ones value of a w-bit counter, used as the saturation ceiling
    function automatic longint unsigned sat_val(input int unsigned w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/modclk_edge_sync.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
module modclk_edge_sync
    import modclk_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     din,
    output edge_ev_t ev
);

    logic       sync1_q, sync2_q, sync3_q;
    logic       rise_q, fall_q;
    logic [1:0] fill_q;

    // Strobes stay quiet until the chain has filled, so a level already
    // present at reset release is not mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
            rise_q  <= (fill_q == 2'd3) && sync2_q && !sync3_q;
            fall_q  <= (fill_q == 2'd3) && !sync2_q && sync3_q;
        end
    end

    assign ev = '{level: sync2_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/modclk_monitor.sv
// Measures period, high time, non-overlap gap and CLKL phase of the
// modulation clock set in USER_CLOCK cycles; flags lock, overlap and loss.
module modclk_monitor
    import modclk_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = 2000,
    parameter int unsigned TOL     = 2
) (
    input  logic             USER_CLOCK,
    input  logic             USER_RESET_N,
    input  logic             MOD_IN,
    input  logic             MODN_IN,
    input  logic             MODL_IN,
    input  logic             CLR_ERR,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic [CNT_W-1:0] GAP,
    output logic [CNT_W-1:0] PHASE_L,
    output logic             MEAS_VALID,
    output logic             LOCKED,
    output logic             ERR_OVERLAP,
    output logic             ERR_TIMEOUT
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_val(CNT_W));

    edge_ev_t mod_ev, modn_ev, modl_ev;

    modclk_edge_sync u_sync_mod  (.clk(USER_CLOCK), .rst_n(USER_RESET_N), .din(MOD_IN),  .ev(mod_ev));
    modclk_edge_sync u_sync_modn (.clk(USER_CLOCK), .rst_n(USER_RESET_N), .din(MODN_IN), .ev(modn_ev));
    modclk_edge_sync u_sync_modl (.clk(USER_CLOCK), .rst_n(USER_RESET_N), .din(MODL_IN), .ev(modl_ev));

    logic unused_c;
    assign unused_c = &{1'b0, modn_ev.fall, modl_ev.fall, modl_ev.level};

    modclk_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_inc_c, diff_c;
    logic [CNT_W-1:0] hi_q, gap_q, ph_q;
    logic             fall_seen_q, gap_seen_q, ph_seen_q;
    logic             have_prev_q, ovl_q;
    logic             timeout_c, emit_c, stable_c, ovl_set_c;

    // A rise on the terminal-count cycle takes priority over the timeout
    assign timeout_c = (state_q != SEARCH) && !mod_ev.rise && (32'(cnt_q) == TIMEOUT - 1);
    assign emit_c    = mod_ev.rise && (state_q != SEARCH);
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign diff_c    = (cnt_q > PERIOD) ? cnt_q - PERIOD : PERIOD - cnt_q;
    assign stable_c  = (32'(diff_c) <= TOL);
    assign ovl_set_c = mod_ev.level && modn_ev.level && ovl_q;

    always_ff @(posedge USER_CLOCK or negedge USER_RESET_N) begin
        if (!USER_RESET_N) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (mod_ev.rise) state_d = MEASURE;
            MEASURE: if (mod_ev.rise) state_d = TRACK;
                     else if (timeout_c) state_d = SEARCH;
            TRACK:   if (timeout_c) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge USER_CLOCK or negedge USER_RESET_N) begin
        if (!USER_RESET_N) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            gap_q       <= '0;
            ph_q        <= '0;
            fall_seen_q <= 1'b0;
            gap_seen_q  <= 1'b0;
            ph_seen_q   <= 1'b0;
            have_prev_q <= 1'b0;
            ovl_q       <= 1'b0;
            PERIOD      <= '0;
            HIGH_TIME   <= '0;
            GAP         <= '0;
            PHASE_L     <= '0;
            MEAS_VALID  <= 1'b0;
            LOCKED      <= 1'b0;
            ERR_OVERLAP <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            ovl_q      <= mod_ev.level && modn_ev.level;
            MEAS_VALID <= emit_c;

            // Per-period shadow timestamps, relative to the latest MOD rise
            if (mod_ev.rise) begin
                cnt_q       <= CNT_W'(1);
                hi_q        <= '0;
                gap_q       <= '0;
                fall_seen_q <= 1'b0;
                gap_seen_q  <= 1'b0;
                ph_seen_q   <= modl_ev.rise;
                ph_q        <= modl_ev.rise ? '0 : CNT_MAX;
            end else begin
                cnt_q <= cnt_inc_c;
                if (mod_ev.fall) begin
                    hi_q        <= cnt_q;
                    fall_seen_q <= 1'b1;
                end
                if (modn_ev.rise && !gap_seen_q) begin
                    gap_seen_q <= 1'b1;
                    gap_q      <= fall_seen_q ? cnt_q - hi_q : '0;
                end
                if (modl_ev.rise && !ph_seen_q) begin
                    ph_seen_q <= 1'b1;
                    ph_q      <= cnt_q;
                end
            end

            if (emit_c) begin
                PERIOD      <= cnt_q;
                HIGH_TIME   <= hi_q;
                GAP         <= gap_q;
                PHASE_L     <= ph_q;
                LOCKED      <= have_prev_q && stable_c;
                have_prev_q <= 1'b1;
            end else if (timeout_c) begin
                LOCKED      <= 1'b0;
                have_prev_q <= 1'b0;
            end

            if (ovl_set_c) begin
                ERR_OVERLAP <= 1'b1;
            end else if (CLR_ERR) begin
                ERR_OVERLAP <= 1'b0;
            end

            if (timeout_c) begin
                ERR_TIMEOUT <= 1'b1;
            end else if (CLR_ERR) begin
                ERR_TIMEOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modclk_monitor.sv
// Directed bench for modclk_monitor: lock, jitter, overlap, timeout,
// missing CLKL, saturation and mid-period reset.
module tb_modclk_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mod_in, modn_in, modl_in, clr_err;
    logic [15:0] period, high_time, gap, phase_l;
    logic        meas_valid, locked, err_overlap, err_timeout;

    logic        s_mod;
    logic [7:0]  s_period, s_high, s_gap, s_phase;
    logic        s_valid, s_locked, s_eovl, s_etmo;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int pulses_snap;

    always #5 clk = ~clk;

    modclk_monitor #(.CNT_W(16), .TIMEOUT(2000), .TOL(2)) dut (
        .USER_CLOCK(clk), .USER_RESET_N(rst_n),
        .MOD_IN(mod_in), .MODN_IN(modn_in), .MODL_IN(modl_in), .CLR_ERR(clr_err),
        .PERIOD(period), .HIGH_TIME(high_time), .GAP(gap), .PHASE_L(phase_l),
        .MEAS_VALID(meas_valid), .LOCKED(locked),
        .ERR_OVERLAP(err_overlap), .ERR_TIMEOUT(err_timeout)
    );

    // Narrow-counter instance to reach saturation in a short run
    modclk_monitor #(.CNT_W(8), .TIMEOUT(1000), .TOL(2)) dut_sat (
        .USER_CLOCK(clk), .USER_RESET_N(rst_n),
        .MOD_IN(s_mod), .MODN_IN(1'b0), .MODL_IN(1'b0), .CLR_ERR(1'b0),
        .PERIOD(s_period), .HIGH_TIME(s_high), .GAP(s_gap), .PHASE_L(s_phase),
        .MEAS_VALID(s_valid), .LOCKED(s_locked),
        .ERR_OVERLAP(s_eovl), .ERR_TIMEOUT(s_etmo)
    );

    always @(posedge clk) begin
        #1;
        if (meas_valid) pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One MOD period starting at the current negedge; gap<0 makes MODN rise
    // before MOD falls, ph<0 leaves MODL low. The report of the previous
    // period is checked 4 cycles after this period's rising edge.
    task automatic drive_period(input int per, input int hi, input int gp, input int ph,
                                input bit expv, input int e_per, input int e_hi,
                                input int e_gap, input int e_ph, input bit e_lock);
        for (int i = 0; i < per; i++) begin
            mod_in  = (i < hi);
            modn_in = (i >= hi + gp) && (i < per - 5);
            modl_in = (ph >= 0) && (i >= ph) && (i < ph + 40);
            @(negedge clk);
            if (i == 3) begin
                check_eq("meas_valid", 32'(meas_valid), 32'(expv));
                if (expv) begin
                    check_eq("period",    32'(period),    32'(e_per));
                    check_eq("high_time", 32'(high_time), 32'(e_hi));
                    check_eq("gap",       32'(gap),       32'(e_gap));
                    check_eq("phase_l",   32'(phase_l),   32'(e_ph));
                    check_eq("locked",    32'(locked),    32'(e_lock));
                end
            end
            if (i == 4) check_eq("valid_pulse_width", 32'(meas_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; mod_in = 1'b0; modn_in = 1'b0; modl_in = 1'b0;
        clr_err = 1'b0; s_mod = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_period",  32'(period),      32'd0);
        check_eq("rst_high",    32'(high_time),   32'd0);
        check_eq("rst_gap",     32'(gap),         32'd0);
        check_eq("rst_phase",   32'(phase_l),     32'd0);
        check_eq("rst_valid",   32'(meas_valid),  32'd0);
        check_eq("rst_locked",  32'(locked),      32'd0);
        check_eq("rst_eovl",    32'(err_overlap), 32'd0);
        check_eq("rst_etmo",    32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal lock, then jitter 101/100 held and 110 dropped
        drive_period(100, 40, 10, 25, 0, 0,   0,  0,  0,  0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 1);
        drive_period(101, 40, 10, 25, 1, 100, 40, 10, 25, 1);
        drive_period(100, 40, 10, 25, 1, 101, 40, 10, 25, 1);
        drive_period(110, 40, 10, 25, 1, 100, 40, 10, 25, 1);
        drive_period(100, 40, 10, 25, 1, 110, 40, 10, 25, 0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 1);
        check_eq("nominal_eovl", 32'(err_overlap), 32'd0);
        check_eq("nominal_etmo", 32'(err_timeout), 32'd0);

        // Overlap: MODN rises 3 cycles before MOD falls
        drive_period(100, 40, -3, 25, 1, 100, 40, 10, 25, 1);
        check_eq("overlap_set", 32'(err_overlap), 32'd1);
        drive_period(100, 40, 10, 25, 1, 100, 40, 0,  25, 1);
        check_eq("overlap_sticky", 32'(err_overlap), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("overlap_clear", 32'(err_overlap), 32'd0);

        // Timeout: last rise driven at start of this period, flag 2003 negedges later
        drive_period(100, 40, 10, 25, 1, 101, 40, 10, 25, 1);
        repeat (1902) @(negedge clk);
        check_eq("timeout_early", 32'(err_timeout), 32'd0);
        check_eq("locked_before_tmo", 32'(locked), 32'd1);
        @(negedge clk);
        check_eq("timeout_set", 32'(err_timeout), 32'd1);
        check_eq("timeout_unlock", 32'(locked), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("timeout_clear", 32'(err_timeout), 32'd0);

        // Restart: first report one period after the first new rise
        drive_period(100, 40, 10, 25, 0, 0,   0,  0,  0,  0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 0);

        // Missing MODL
        drive_period(100, 40, 10, -1, 1, 100, 40, 10, 25, 1);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 'hFFFF, 1);

        // Reset while MOD is high
        mod_in = 1'b1; modn_in = 1'b0; modl_in = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_period", 32'(period), 32'd0);
        check_eq("midrst_locked", 32'(locked), 32'd0);
        check_eq("midrst_phase",  32'(phase_l), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses_snap = pulses;
        repeat (20) @(negedge clk);
        mod_in = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("midrst_no_valid", 32'(pulses), 32'(pulses_snap));
        drive_period(100, 40, 10, 25, 0, 0,   0,  0,  0,  0);
        drive_period(100, 40, 10, 25, 1, 100, 40, 10, 25, 0);
        mod_in = 1'b0; modn_in = 1'b0; modl_in = 1'b0;

        // Saturation on the 8-bit instance: 300-cycle periods, no MODL
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 300; i++) begin
                s_mod = (i < 40);
                @(negedge clk);
            end
        end
        s_mod = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("sat_valid",  32'(s_valid),  32'd1);
        check_eq("sat_period", 32'(s_period), 32'hFF);
        check_eq("sat_phase",  32'(s_phase),  32'hFF);
        check_eq("sat_high",   32'(s_high),   32'd40);
        check_eq("sat_etmo",   32'(s_etmo),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
